fifo_rr_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the team's single-clock 8-bit FIFO among NUM_REQ producers. Each producer sends bursts over a valid/ready handshake. A grant is locked for one burst, which ends on req_last or after MAX_BURST beats. The block drives the FIFO's wr_en and data in, and uses the FIFO's occupancy count to stay overflow-safe despite its registered write path.

---
 rtl/fifo_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_rr_wr_arbiter.sv | 132 +++++++++++++
 tb/tb_fifo_rr_wr_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int GNT_W  = 3;
  localparam int STAT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set bit of valid_i at or above start_i, wrapping modulo N.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     valid_i,
  input  logic [GNT_W-1:0] start_i,
  output logic             found_o,
  output logic [GNT_W-1:0] idx_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so start_i lands at bit 0, then take the lowest set bit.
  always_comb begin
    dbl     = {valid_i, valid_i} >> start_i;
    rot     = dbl[N-1:0];
    found_o = |rot;
    idx_o   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) idx_o = GNT_W'((int'(start_i) + k) % N);
    end
  end

endmodule

// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin burst arbiter for the single FIFO write port, with a registered write path.
// Define FIFO_ARB_STATS_EN to add per-requester beat counters and a stall counter.
module fifo_rr_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 64,
  parameter int CNT_W     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [CNT_W-1:0]          fifo_count,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_din,
  output logic [GNT_W-1:0]          gnt_id,
  output logic                      busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [7:0]     MAXB_C  = 8'(MAX_BURST);

  arb_state_e         state_q;
  logic [GNT_W-1:0]   gnt_q, rr_q, rr_d;
  logic [7:0]         beat_q, beat_d;
  logic               wr_en_q;
  logic [DATA_W-1:0]  din_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic               sel_valid, sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic               space_ok, accept, burst_end;
  logic               pick_found;
  logic [GNT_W-1:0]   pick_idx;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .start_i (rr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    gnt_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_oh[i] = (gnt_q == GNT_W'(i));
      if (gnt_oh[i]) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign sel_valid = |(req_valid & gnt_oh);
  assign sel_last  = |(req_last & gnt_oh);

  // The registered write still in flight is counted as occupied; concurrent reads are ignored.
  assign space_ok  = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, wr_en_q}) < DEPTH_C;
  assign req_ready = (state_q == BURST && space_ok && !rst) ? gnt_oh : '0;
  assign accept    = (state_q == BURST) && space_ok && sel_valid;

  assign beat_d    = beat_q + 8'd1;
  assign burst_end = sel_last || (beat_d == MAXB_C);
  assign rr_d      = (gnt_q == GNT_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= BURST;
            gnt_q   <= pick_idx;
            beat_q  <= '0;
          end
        end
        BURST: begin
          if (accept) begin
            wr_en_q <= 1'b1;
            din_q   <= sel_data;
            beat_q  <= beat_d;
            if (burst_end) begin
              state_q <= IDLE;
              rr_q    <= rr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_wr_en = wr_en_q;
  assign fifo_din   = din_q;
  assign gnt_id     = gnt_q;
  assign busy       = (state_q == BURST);

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] stall_q;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    logic [STAT_W-1:0] beats_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      beats_q <= '0;
      else if (accept && gnt_oh[g] && beats_q != '1) beats_q <= beats_q + STAT_W'(1);
    end
    assign stat_beats[g*STAT_W +: STAT_W] = beats_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                          stall_q <= '0;
    else if (state_q == BURST && sel_valid && !space_ok && stall_q != '1) stall_q <= stall_q + STAT_W'(1);
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Scoreboard bench for fifo_rr_wr_arbiter: directed scenarios plus randomized traffic vs a rule-level model.
module tb_fifo_rr_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N = 4, DW = 8, DEPTH = 64, CW = 8, MAXB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_last, req_ready;
  logic [N*DW-1:0] req_data;
  logic [CW-1:0]   fifo_count;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_din;
  logic [2:0]      gnt_id;
  logic            busy;
`ifdef FIFO_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
  logic [15:0]     stat_stall;
`endif

  fifo_rr_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .fifo_count(fifo_count), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .gnt_id(gnt_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_beats(stat_beats), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Producer beat queues: {last, data}
  logic [8:0] pbuf [N][256];
  int phead[N], ptail[N];
  bit gate[N];

  // Reference model state
  bit m_busy, m_wr;
  int m_gnt, m_rr, m_beats, m_stall;
  int m_sbeats[N];
  int sb[$];
  int glog[$];
  int fcnt, fixed_cnt, drain_pct, maxcnt, wr_seen;

  task automatic push_burst(int r, int n, int base, bit with_last);
    for (int k = 0; k < n; k++) begin
      pbuf[r][ptail[r] % 256] = {(with_last && k == n - 1), 8'(base + k)};
      ptail[r]++;
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_wr = 0; m_gnt = 0; m_rr = 0; m_beats = 0; m_stall = 0;
    for (int i = 0; i < N; i++) m_sbeats[i] = 0;
    sb.delete();
    glog.delete();
    fcnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("rst_wr_en", int'(fifo_wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock of stimulus, model step and output comparison; starts and ends just after a rising edge.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    bit sp, acc, old_wr, found;
    int w;
    logic [8:0] hb;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (phead[i] != ptail[i]) && gate[i];
      hb = req_valid[i] ? pbuf[i][phead[i] % 256] : 9'($urandom);
      req_last[i] = hb[8];
      req_data[i*DW +: DW] = hb[7:0];
    end
    fifo_count = (fixed_cnt >= 0) ? CW'(fixed_cnt) : CW'(fcnt);
    #1;
    sp = (int'(fifo_count) + int'(m_wr)) < DEPTH;
    exp_rdy = '0;
    if (m_busy && sp) exp_rdy[m_gnt] = 1'b1;
    chk("req_ready", int'(req_ready), int'(exp_rdy));
    acc = m_busy && sp && req_valid[m_gnt];
    if (m_busy && !sp && req_valid[m_gnt]) m_stall++;
    old_wr = m_wr;
    m_wr = acc;
    if (!m_busy) begin
      found = 0; w = 0;
      for (int k = 0; k < N; k++)
        if (!found && req_valid[(m_rr + k) % N]) begin found = 1; w = (m_rr + k) % N; end
      if (found) begin
        m_busy = 1; m_gnt = w; m_beats = 0;
        glog.push_back(w);
      end
    end else if (acc) begin
      hb = pbuf[m_gnt][phead[m_gnt] % 256];
      sb.push_back(m_gnt * 256 + int'(hb[7:0]));
      m_sbeats[m_gnt]++;
      phead[m_gnt]++;
      m_beats++;
      if (hb[8] || m_beats == MAXB) begin
        m_busy = 0;
        m_rr = (m_gnt + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    if (fixed_cnt < 0) begin
      fcnt += int'(old_wr);
      if (fcnt > maxcnt) maxcnt = fcnt;
      if (fcnt > 0 && $urandom_range(99) < drain_pct) fcnt--;
    end
    chk("busy", int'(busy), int'(m_busy));
    chk("gnt_id", int'(gnt_id), m_gnt);
    chk("fifo_wr_en", int'(fifo_wr_en), int'(m_wr));
  endtask

  task automatic run_idle(int bound);
    int n = 0;
    bit pend;
    for (int i = 0; i < N; i++) gate[i] = 1;
    pend = 1;
    while (pend && n < bound) begin
      pend = m_busy || m_wr;
      for (int i = 0; i < N; i++) if (phead[i] != ptail[i]) pend = 1;
      if (pend) begin cycle(); n++; end
    end
    chk("run_idle_timeout", int'(n < bound), 1);
  endtask

  // Monitor: every FIFO write must match the oldest expected handshake.
  always @(negedge clk) begin
    int e;
    if (!rst && fifo_wr_en) begin
      wr_seen++;
      if (sb.size() == 0) chk("sb_unexpected_write", 1, 0);
      else begin
        e = sb.pop_front();
        chk("fifo_din", int'(fifo_din), e % 256);
        chk("write_owner", int'(gnt_id), e / 256);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, idle_cnt;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_count = '0;
    for (int i = 0; i < N; i++) begin phead[i] = 0; ptail[i] = 0; gate[i] = 1; end
    fixed_cnt = -1; drain_pct = 50; maxcnt = 0; wr_seen = 0;
    do_reset();

    // Single burst from requester 2
    fixed_cnt = 0;
    w0 = wr_seen;
    push_burst(2, 3, 8'hA1, 1);
    cycle();
    chk("t1_gnt", int'(gnt_id), 2);
    chk("t1_busy", int'(busy), 1);
    repeat (5) cycle();
    chk("t1_writes", wr_seen - w0, 3);
    chk("t1_idle", int'(busy), 0);
    // Pointer now at 3: requester 3 beats requester 0
    push_burst(0, 1, 8'h10, 1);
    push_burst(3, 1, 8'h30, 1);
    cycle();
    chk("t1_rr_ptr", int'(gnt_id), 3);
    run_idle(50);

    // Round-robin fairness with one bubble between bursts
    do_reset();
    for (int r = 0; r < N; r++) begin
      push_burst(r, 2, 16 * r, 1);
      push_burst(r, 2, 16 * r + 8, 1);
    end
    idle_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      cycle();
      if (!busy) idle_cnt++;
    end
    chk("t2_bubbles", idle_cnt, 4);
    chk("t2_grants", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++) chk("t2_order", glog[k], k % N);
    run_idle(200);

    // MAX_BURST forced release
    do_reset();
    push_burst(0, 20, 8'h40, 1);
    push_burst(1, 2, 8'hC0, 1);
    w0 = wr_seen;
    run_idle(200);
    chk("t3_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t3_g0", glog[0], 0);
      chk("t3_g1", glog[1], 1);
      chk("t3_g2", glog[2], 0);
    end
    chk("t3_writes", wr_seen - w0, 22);

    // Backpressure around full
    do_reset();
    push_burst(0, 8, 8'h60, 1);
    w0 = wr_seen;
    fixed_cnt = 0;
    cycle();
    fixed_cnt = 63;
    cycle();
    cycle();
    fixed_cnt = 64;
    repeat (5) cycle();
    chk("t4_one_beat", wr_seen - w0, 1);
    chk("t4_ready_low", int'(req_ready), 0);
    fixed_cnt = 60;
    run_idle(100);
    chk("t4_all_beats", wr_seen - w0, 8);
`ifdef FIFO_ARB_STATS_EN
    for (int r = 0; r < N; r++) chk("t4_stat_beats", int'(stat_beats[r*16 +: 16]), m_sbeats[r]);
    chk("t4_stat_beats0", int'(stat_beats[15:0]), 8);
    chk("t4_stat_stall", int'(stat_stall), m_stall);
    chk("t4_stat_stall_c", int'(stat_stall), 6);
`endif

    // Reset mid-burst
    do_reset();
    fixed_cnt = 0;
    push_burst(1, 1, 8'h11, 1);
    run_idle(20);
    w0 = wr_seen;
    push_burst(2, 5, 8'h21, 1);
    cycle();
    chk("t5_gnt", int'(gnt_id), 2);
    cycle();
    cycle();
    do_reset();
    push_burst(0, 1, 8'h01, 1);
    cycle();
    chk("t5_gnt_after_rst", int'(gnt_id), 0);
    run_idle(50);
    chk("t5_writes", wr_seen - w0, 5);

    // Randomized traffic with an emulated draining FIFO
    do_reset();
    fixed_cnt = -1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) drain_pct = $urandom_range(100, 10);
      for (int r = 0; r < N; r++) begin
        gate[r] = ($urandom_range(99) < 80);
        if (phead[r] == ptail[r] && $urandom_range(2) == 0)
          push_burst(r, $urandom_range(24, 1), $urandom_range(255), 1);
      end
      cycle();
    end
    drain_pct = 100;
    run_idle(2000);
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_no_overflow", int'(maxcnt <= DEPTH), 1);
`ifdef FIFO_ARB_STATS_EN
    for (int r = 0; r < N; r++) chk("rand_stat_beats", int'(stat_beats[r*16 +: 16]), m_sbeats[r]);
    chk("rand_stat_stall", int'(stat_stall), m_stall);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
